mem_word_master: RTL and testbench

Bus initiator that sits between the CPU datapath and the byte-wide main memory. It turns one 16-bit or 8-bit load/store request into one or two byte-wide memory cycles. It drives the memory's `din`, `addrin`, `read` and `write` inputs and samples its 16-bit `dout`, which carries `{8'h00, byte}` while `read` is high and is tri-stated otherwise. Words are little-endian: the low byte is at `addr` and the high byte is at `addr+1`.

---
 rtl/mem_word_master.sv | 124 ++++++++++++
 tb/tb_mem_word_master.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_word_master.sv
// Bus initiator: turns one 8/16-bit load/store into one or two byte-wide memory cycles.
// Words are little-endian; the high byte lives at addr+1 (wrapping at 16'hFFFF).
module mem_word_master (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic        word,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        busy,
    output logic        done,
    output logic [7:0]  mem_din,
    output logic [15:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [15:0] mem_dout
);

    typedef enum logic [2:0] {
        StIdle,
        StRdLo,
        StRdHi,
        StWrLo,
        StWrHi,
        StDone
    } state_e;

    state_e      r_state;
    state_e      w_state_nxt;
    logic        r_word;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_rdata;
    logic [15:0] w_addr_inc;
    logic        w_unused_dout;

    assign w_addr_inc    = r_addr + 16'd1;
    assign w_unused_dout = ^mem_dout[15:8];
    assign rdata         = r_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (req) begin
                    w_state_nxt = we ? StWrLo : StRdLo;
                end
            end
            StRdLo:  w_state_nxt = r_word ? StRdHi : StDone;
            StRdHi:  w_state_nxt = StDone;
            StWrLo:  w_state_nxt = r_word ? StWrHi : StDone;
            StWrHi:  w_state_nxt = StDone;
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        busy      = (r_state != StIdle);
        done      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = 16'h0000;
        mem_din   = 8'h00;
        unique case (r_state)
            StRdLo: begin
                mem_read = 1'b1;
                mem_addr = r_addr;
            end
            StRdHi: begin
                mem_read = 1'b1;
                mem_addr = w_addr_inc;
            end
            StWrLo: begin
                mem_write = 1'b1;
                mem_addr  = r_addr;
                mem_din   = r_wdata[7:0];
            end
            StWrHi: begin
                mem_write = 1'b1;
                mem_addr  = w_addr_inc;
                mem_din   = r_wdata[15:8];
            end
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    // Request fields are captured only on accept; rdata is touched only by read cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word  <= 1'b0;
            r_addr  <= 16'h0000;
            r_wdata <= 16'h0000;
            r_rdata <= 16'h0000;
        end else begin
            if (r_state == StIdle && req) begin
                r_word  <= word;
                r_addr  <= addr;
                r_wdata <= wdata;
            end
            if (r_state == StRdLo) begin
                r_rdata[7:0] <= mem_dout[7:0];
                if (!r_word) begin
                    r_rdata[15:8] <= 8'h00;
                end
            end
            if (r_state == StRdHi) begin
                r_rdata[15:8] <= mem_dout[7:0];
            end
        end
    end

endmodule

// File: tb/tb_mem_word_master.sv
// Self-checking bench for mem_word_master: byte-array memory model, table vectors,
// random accesses against a shadow memory, plus ignored-req and mid-store reset sequences.
module tb_mem_word_master;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        we;
    logic        word;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        busy;
    logic        done;
    logic [7:0]  mem_din;
    logic [15:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_dout;

    logic [7:0]  mem     [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic [15:0] exp_rdata;
    int          n_vec;
    int          n_err;

    mem_word_master dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .word      (word),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .busy      (busy),
        .done      (done),
        .mem_din   (mem_din),
        .mem_addr  (mem_addr),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_dout  (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: combinational read, write committed at the rising edge.
    assign mem_dout = mem_read ? {8'h00, mem[mem_addr]} : 16'hA5A5;
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_din;
    end

    typedef struct {
        logic        we;
        logic        word;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_done"}, 32'(done), 32'd0);
        chk({name, "_rd"}, 32'(mem_read), 32'd0);
        chk({name, "_wr"}, 32'(mem_write), 32'd0);
        chk({name, "_maddr"}, 32'(mem_addr), 32'd0);
        chk({name, "_mdin"}, 32'(mem_din), 32'd0);
    endtask

    // Higher-level model: update shadow memory / expected rdata from the access itself.
    task automatic model_access(input logic w, input logic wd, input logic [15:0] a,
                                input logic [15:0] d);
        logic [15:0] a1;
        a1 = a + 16'd1;
        if (w) begin
            ref_mem[a] = d[7:0];
            if (wd) ref_mem[a1] = d[15:8];
        end else begin
            exp_rdata = wd ? {ref_mem[a1], ref_mem[a]} : {8'h00, ref_mem[a]};
        end
    endtask

    task automatic do_access(input logic w, input logic wd, input logic [15:0] a,
                             input logic [15:0] d);
        int busy_cnt;
        int done_cnt;
        int done_k;
        int exp_k;
        logic [15:0] a1;
        a1 = a + 16'd1;
        @(negedge clk);
        req = 1'b1; we = w; word = wd; addr = a; wdata = d;
        @(posedge clk);
        #1;
        req = 1'b0; addr = 16'h0; wdata = 16'h0;
        busy_cnt = 0; done_cnt = 0; done_k = 0;
        for (int k = 1; k <= 6; k++) begin
            if (mem_read && mem_write) chk("excl", 32'(mem_read & mem_write), 32'd0);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_k == 0) done_k = k;
            end
            @(posedge clk);
            #1;
        end
        model_access(w, wd, a, d);
        exp_k = wd ? 3 : 2;
        chk("done_cycle", 32'(done_k), 32'(exp_k));
        chk("done_count", 32'(done_cnt), 32'd1);
        chk("busy_cycles", 32'(busy_cnt), 32'(exp_k));
        chk("rdata", 32'(rdata), 32'(exp_rdata));
        if (w) begin
            chk("mem_lo", 32'(mem[a]), 32'(ref_mem[a]));
            if (wd) chk("mem_hi", 32'(mem[a1]), 32'(ref_mem[a1]));
        end
    endtask

    vec_t vecs [8];

    initial begin
        int busy_seen;
        int done_seen;
        n_vec = 0; n_err = 0;
        exp_rdata = 16'h0000;
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        rst_n = 1'b0; req = 1'b0; we = 1'b0; word = 1'b0; addr = 16'h0; wdata = 16'h0;

        vecs[0] = '{1'b1, 1'b0, 16'h0040, 16'h775A, 16'h0000};
        vecs[1] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'h005A};
        vecs[2] = '{1'b1, 1'b1, 16'h1000, 16'hBEEF, 16'h005A};
        vecs[3] = '{1'b0, 1'b1, 16'h1000, 16'h0000, 16'hBEEF};
        vecs[4] = '{1'b1, 1'b1, 16'hFFFF, 16'h1234, 16'hBEEF};
        vecs[5] = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h1234};
        vecs[6] = '{1'b0, 1'b0, 16'h1001, 16'h0000, 16'h00BE};
        vecs[7] = '{1'b0, 1'b1, 16'h0FFF, 16'h0000, 16'hEF00};

        #12;
        chk("reset_rdata", 32'(rdata), 32'h0);
        chk_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle_outputs("idle");

        for (int i = 0; i < 8; i++) begin
            do_access(vecs[i].we, vecs[i].word, vecs[i].addr, vecs[i].wdata);
            chk($sformatf("vec%0d_rdata", i), 32'(rdata), 32'(vecs[i].exp));
        end
        chk("wrap_mem_ffff", 32'(mem[16'hFFFF]), 32'h34);
        chk("wrap_mem_0000", 32'(mem[16'h0000]), 32'h12);
        chk("mem_1000", 32'(mem[16'h1000]), 32'hEF);
        chk("mem_1001", 32'(mem[16'h1001]), 32'hBE);

        // req pulsed during RD_HI of a word load must be ignored.
        mem[16'h2000] = 8'h99;
        ref_mem[16'h2000] = 8'h99;
        @(negedge clk);
        req = 1'b1; we = 1'b0; word = 1'b1; addr = 16'h1000;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        chk("rdhi_state_read", 32'(mem_read), 32'd1);
        chk("rdhi_addr", 32'(mem_addr), 32'h1001);
        req = 1'b1; word = 1'b0; addr = 16'h2000;
        @(posedge clk); #1;
        req = 1'b0;
        chk("ign_done", 32'(done), 32'd1);
        busy_seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (busy || mem_read) busy_seen++;
        end
        chk("ign_no_second", 32'(busy_seen), 32'd0);
        chk("ign_rdata", 32'(rdata), 32'hBEEF);

        // Reset during WR_HI of a word store: low byte committed, high byte not, no done.
        mem[16'h0201] = 8'h3C;
        ref_mem[16'h0201] = 8'h3C;
        @(negedge clk);
        req = 1'b1; we = 1'b1; word = 1'b1; addr = 16'h0200; wdata = 16'hCAFE;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        chk("wrhi_din", 32'(mem_din), 32'hCA);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk_idle_outputs("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        ref_mem[16'h0200] = 8'hFE;
        exp_rdata = 16'h0000;
        done_seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (done || busy) done_seen++;
        end
        chk("rst_no_done", 32'(done_seen), 32'd0);
        chk("rst_mem_lo", 32'(mem[16'h0200]), 32'hFE);
        chk("rst_mem_hi", 32'(mem[16'h0201]), 32'h3C);

        // Random accesses in a small window plus the wrap region.
        for (int i = 0; i < 150; i++) begin
            logic [15:0] ra;
            ra = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3))
                                              : 16'(16'h3000 + $urandom_range(0, 15));
            do_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra,
                      16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
